// File: rtl/dmem_arbiter.sv
// dmem_arbiter: sequences the shared 1024-word data memory between the pipeline (p) and loader (l) ports
module dmem_arbiter #(
  parameter int ADDR_LIMIT = 1023,
  parameter int MEM_LAT = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [63:0] p_addr,
  input  logic [63:0] p_wdata,
  output logic        p_done,
  output logic [63:0] p_rdata,
  output logic        p_err,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [63:0] l_addr,
  input  logic [63:0] l_wdata,
  output logic        l_done,
  output logic [63:0] l_rdata,
  output logic        l_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        m_stall,
  output logic        busy
);
  localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;
  state_t state;
  logic owner, we_q, l_win, p_win, bad, last;
  logic [LW-1:0] lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic [63:0] sel_addr;
  always_comb begin
    l_win = l_req & (~p_req | starve_cnt == SW'(STARVE_MAX));
    p_win = p_req & ~l_win;
    sel_addr = l_win ? l_addr : p_addr;
    bad = sel_addr > 64'(ADDR_LIMIT);
    last = lat_cnt == LW'(MEM_LAT - 1);
  end
  assign m_stall = p_req & ~p_done;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      we_q <= 1'b0;
      lat_cnt <= '0;
      starve_cnt <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      p_done <= 1'b0;
      l_done <= 1'b0;
      p_err <= 1'b0;
      l_err <= 1'b0;
      p_rdata <= '0;
      l_rdata <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      p_done <= 1'b0;
      l_done <= 1'b0;
      case (state)
        IDLE: begin
          starve_cnt <= (~l_req | l_win) ? '0 :
                        (p_win && starve_cnt != SW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
          if (l_win | p_win) begin
            owner <= l_win;
            we_q <= l_win ? l_we : p_we;
            mem_addr <= sel_addr[9:0];
            mem_wdata <= l_win ? l_wdata : p_wdata;
            lat_cnt <= '0;
            if (l_win) l_err <= bad;
            else p_err <= bad;
            if (bad) begin
              state <= ERR;
              l_done <= l_win;
              p_done <= p_win;
            end else begin
              state <= ACCESS;
              mem_en <= 1'b1;
              mem_we <= l_win ? l_we : p_we;
            end
          end
        end
        ACCESS: begin
          if (last) begin
            state <= DONE;
            l_done <= owner;
            p_done <= ~owner;
            if (~we_q & owner) l_rdata <= mem_rdata;
            if (~we_q & ~owner) p_rdata <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
